ei_axi_slave_mem: RTL and testbench
===================================

# ei_axi_slave_mem

Synthesizable AXI slave memory that sits directly downstream of the team's AXI master/BFM and terminates the `ei_axi_interface` write and read channels. It accepts write bursts (AW, W) and read bursts (AR, R) with FIXED, INCR or WRAP addressing. Write data goes into an internal word-addressed array, and reads return data from that array. There is no write-response channel, matching the interface signal set.

## Interface
- ADD_SIZE, 32, address width
- DATA_SIZE, 32, data width; power of two, ≥8
- LEN_SIZE, 4, burst length field width (beats = LEN+1)
- S_SIZE, 3, transfer size field width
- BURST_SIZE, 2, burst type field width
- MEM_DEPTH, 256, number of DATA_SIZE words; power of two
- ACLK  in  1  clock, all state on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWADDR/AWLEN/AWSIZE/AWBURST  in  ADD_SIZE/LEN_SIZE/S_SIZE/BURST_SIZE  write address channel
- AWVALID in 1, AWREADY out 1  write address handshake
- WDATA  in  DATA_SIZE, WLAST in 1, WVALID in 1, WREADY out 1  write data channel
- ARADDR/ARLEN/ARSIZE/ARBURST  in  as AW  read address channel
- ARVALID in 1, ARREADY out 1  read address handshake
- RDATA out DATA_SIZE, RLAST out 1, RVALID out 1, RREADY in 1  read data channel

## Operation
- **Decided:** one clock; reset is asynchronous and active-high.
- **Reset values:** AWREADY=0, WREADY=0, ARREADY=0, RVALID=0, RLAST=0, RDATA=0. The memory array is not reset.
- **Write FSM:** W_IDLE → W_DATA → W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch addr/len/size/burst, clear the beat counter, go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY writes one beat.
  - After beat AWLEN+1: go to W_IDLE.
- **Read FSM:** R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch fields, load RDATA with mem[first addr], set RVALID=1, set RLAST=(ARLEN==0).
  - R_DATA: on RVALID&&RREADY with RLAST=0, load the next beat.
  - On RVALID&&RREADY with RLAST=1: RVALID=0, RLAST=0, go to R_IDLE.
  - While RREADY=0, RDATA/RLAST/RVALID hold stable.
- **Channel independence:** the write and read FSMs are fully independent and may run concurrently.
- **Address arithmetic:**
  - Byte address. Word index = addr[log2(DATA_SIZE/8) +: log2(MEM_DEPTH)], i.e. modulo MEM_DEPTH.
  - Beat increment = 2^SIZE bytes. SIZE is clamped to log2(DATA_SIZE/8).
- **Burst types:**
  - FIXED (00): address constant for all beats.
  - INCR (01): address += 2^SIZE per beat.
  - WRAP (10): boundary = (LEN+1)·2^SIZE. Next addr = (addr & ~(boundary−1)) | ((addr+2^SIZE) & (boundary−1)). Valid only for LEN ∈ {1,3,7,15}; any other LEN is treated as INCR.
  - Reserved (11): treated as INCR.
- **Narrow transfers:** only byte lanes [addr mod (DATA_SIZE/8), +2^SIZE) are written. Other bytes of the word are preserved. Reads always return the full word.
- **Burst termination:** a write burst terminates on the beat count only; WLAST does not end the burst.
- **Write/read collision:** a read-load and a write to the same word in the same cycle returns the old (pre-write) data.

## Timing
- AW or AR handshake at edge N: WREADY=1 / RVALID=1 visible after edge N (the next cycle).
- Write beat latency: data is in memory after the handshake edge. A read issued afterwards observes it.
- Read throughput: one beat per cycle while RREADY=1.
- Back-to-back bursts: after the final handshake at edge N, AWREADY/ARREADY=1 after edge N. One idle cycle between bursts per channel.
- ARESET assertion mid-burst: outputs go to reset values immediately (asynchronously), both FSMs go to IDLE, and partial bursts are abandoned. Beats already written remain in memory.
- First cycle after ARESET deassertion: AWREADY=1 and ARREADY=1 after the first rising edge.

## Configuration
- EI_AXI_SLV_WLAST_CHK_EN
  - **Defined:** adds output WLAST_ERR (1 bit, reset 0). It is sticky and cleared only by ARESET. It sets on the clock after any W beat where WLAST ≠ (beat is final).
  - **Undefined:** no WLAST_ERR port, and WLAST is ignored entirely.
  - Data behaviour is identical in both builds.

## Test plan
- **INCR write then read:** AW addr 0x10, LEN 3, SIZE 2, INCR; W 0xA0..0xA3. AR same fields → RDATA 0xA0,0xA1,0xA2,0xA3, RLAST on beat 4 only.
- **WRAP read:** preload words 0x20..0x2C with 1..4. AR addr 0x28, LEN 3, SIZE 2, WRAP → RDATA 3,4,1,2.
- **Narrow/FIXED write:** word 0x40=0xFFFFFFFF. AW 0x41, LEN 1, SIZE 0, FIXED; W 0x0000_5500 then 0x0000_6600 → read 0x40 returns 0xFFFF66FF.
- **Backpressure:** 4-beat read with RREADY toggling 1,0,0,1,1,0,1 → RDATA/RLAST stable while stalled; exactly 4 beats delivered in order.
- **Reset mid-burst:** assert ARESET after beat 2 of a 4-beat write → RVALID/WREADY=0 immediately. After release, AWREADY=1 in 1 cycle. Beats 1–2 are readable, beats 3–4 hold old contents.
- **WLAST check (macro defined):** 4-beat write with WLAST on beat 2 → WLAST_ERR=1 after that cycle and held until ARESET. All 4 beats are still written.

Source files
------------

// File: rtl/ei_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// ei_axi_slave_mem
//   AXI slave memory terminating the ei_axi_interface write (AW, W) and read
//   (AR, R) channels. FIXED, INCR and WRAP bursts, narrow writes via byte
//   lanes, word-addressed internal array. No write-response channel.
//
// Optional feature macro: EI_AXI_SLV_WLAST_CHK_EN
//   defined   -> extra output WLAST_ERR, sticky flag raised when WLAST does not
//                match the final beat of a write burst (cleared by ARESET only)
//   undefined -> no WLAST_ERR port, WLAST is ignored
//
// Ports
//   ACLK, ARESET                    clock, asynchronous active-high reset
//   AWADDR/AWLEN/AWSIZE/AWBURST     write address channel, AWVALID/AWREADY
//   WDATA/WLAST                     write data channel, WVALID/WREADY
//   ARADDR/ARLEN/ARSIZE/ARBURST     read address channel, ARVALID/ARREADY
//   RDATA/RLAST                     read data channel, RVALID/RREADY
//   WLAST_ERR                       (macro only) sticky WLAST mismatch flag
// ----------------------------------------------------------------------------
module ei_axi_slave_mem #(
  parameter int ADD_SIZE   = 32,
  parameter int DATA_SIZE  = 32,
  parameter int LEN_SIZE   = 4,
  parameter int S_SIZE     = 3,
  parameter int BURST_SIZE = 2,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADD_SIZE-1:0]   AWADDR,
  input  logic [LEN_SIZE-1:0]   AWLEN,
  input  logic [S_SIZE-1:0]     AWSIZE,
  input  logic [BURST_SIZE-1:0] AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_SIZE-1:0]  WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [ADD_SIZE-1:0]   ARADDR,
  input  logic [LEN_SIZE-1:0]   ARLEN,
  input  logic [S_SIZE-1:0]     ARSIZE,
  input  logic [BURST_SIZE-1:0] ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_SIZE-1:0]  RDATA,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
`ifdef EI_AXI_SLV_WLAST_CHK_EN
  ,
  output logic                  WLAST_ERR
`endif
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);

  typedef enum logic {W_IDLE, W_DATA} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Transfer size can never exceed the bus width.
  function automatic logic [S_SIZE-1:0] f_clamp_size(input logic [S_SIZE-1:0] size);
    if (size > S_SIZE'(OFFW)) f_clamp_size = S_SIZE'(OFFW);
    else                      f_clamp_size = size;
  endfunction

  // Word index: byte address with the lane offset dropped, modulo MEM_DEPTH.
  function automatic logic [IDXW-1:0] f_idx(input logic [ADD_SIZE-1:0] addr);
    f_idx = addr[OFFW +: IDXW];
  endfunction

  // Address of the following beat; illegal WRAP lengths and the reserved
  // burst encoding fall back to INCR.
  function automatic logic [ADD_SIZE-1:0] f_next_addr(
    input logic [ADD_SIZE-1:0]   addr,
    input logic [LEN_SIZE-1:0]   len,
    input logic [S_SIZE-1:0]     size,
    input logic [BURST_SIZE-1:0] burst
  );
    logic [ADD_SIZE-1:0] incr;
    logic [ADD_SIZE-1:0] mask;
    logic                wrap_ok;
    incr    = ADD_SIZE'(1) << size;
    mask    = ((ADD_SIZE'(len) + ADD_SIZE'(1)) << size) - ADD_SIZE'(1);
    wrap_ok = (len == LEN_SIZE'(1)) || (len == LEN_SIZE'(3)) ||
              (len == LEN_SIZE'(7)) || (len == LEN_SIZE'(15));
    case (burst)
      BURST_SIZE'(0): f_next_addr = addr;
      BURST_SIZE'(2): begin
        if (wrap_ok) f_next_addr = (addr & ~mask) | ((addr + incr) & mask);
        else         f_next_addr = addr + incr;
      end
      default:        f_next_addr = addr + incr;
    endcase
  endfunction

  // Byte lanes [addr mod BYTES, +2^size) are the ones a narrow beat touches.
  function automatic logic [BYTES-1:0] f_byte_en(
    input logic [ADD_SIZE-1:0] addr,
    input logic [S_SIZE-1:0]   size
  );
    logic [ADD_SIZE-1:0] off;
    logic [ADD_SIZE-1:0] nb;
    off = addr & ADD_SIZE'(BYTES - 1);
    nb  = ADD_SIZE'(1) << size;
    for (int b = 0; b < BYTES; b++) begin
      f_byte_en[b] = (ADD_SIZE'(b) >= off) && (ADD_SIZE'(b) < off + nb);
    end
  endfunction

  logic [DATA_SIZE-1:0]  r_mem [MEM_DEPTH];

  wstate_t               r_wstate;
  logic [ADD_SIZE-1:0]   r_waddr;
  logic [LEN_SIZE-1:0]   r_wlen;
  logic [LEN_SIZE-1:0]   r_wbeat;
  logic [S_SIZE-1:0]     r_wsize;
  logic [BURST_SIZE-1:0] r_wburst;
  logic                  r_awready;
  logic                  r_wready;

  rstate_t               r_rstate;
  logic [ADD_SIZE-1:0]   r_raddr;   // address of the next beat to load
  logic [LEN_SIZE-1:0]   r_rlen;
  logic [LEN_SIZE-1:0]   r_rbeat;   // index of the beat currently on RDATA
  logic [S_SIZE-1:0]     r_rsize;
  logic [BURST_SIZE-1:0] r_rburst;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [DATA_SIZE-1:0]  r_rdata;

  logic                  w_wr_en;
  logic                  w_wr_last;
  logic [IDXW-1:0]       w_wr_idx;
  logic [BYTES-1:0]      w_wr_be;
  logic [S_SIZE-1:0]     w_awsize;
  logic [S_SIZE-1:0]     w_arsize;

  // WREADY is only ever high in W_DATA, so it qualifies the beat on its own.
  assign w_wr_en   = WVALID & r_wready;
  assign w_wr_last = (r_wbeat == r_wlen);
  assign w_wr_idx  = f_idx(r_waddr);
  assign w_wr_be   = f_byte_en(r_waddr, r_wsize);
  assign w_awsize  = f_clamp_size(AWSIZE);
  assign w_arsize  = f_clamp_size(ARSIZE);

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RDATA   = r_rdata;

`ifdef EI_AXI_SLV_WLAST_CHK_EN
  logic r_wlast_err;
  assign WLAST_ERR = r_wlast_err;
`else
  logic w_unused_wlast;
  assign w_unused_wlast = WLAST;
`endif

  // Memory array: byte-lane writes, never reset.
  always_ff @(posedge ACLK) begin
    if (w_wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // Write FSM: address accept, then beat counting; WLAST never ends a burst.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_waddr   <= ADD_SIZE'(0);
      r_wlen    <= LEN_SIZE'(0);
      r_wbeat   <= LEN_SIZE'(0);
      r_wsize   <= S_SIZE'(0);
      r_wburst  <= BURST_SIZE'(0);
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
`ifdef EI_AXI_SLV_WLAST_CHK_EN
      r_wlast_err <= 1'b0;
`endif
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AWVALID && r_awready) begin
            r_waddr   <= AWADDR;
            r_wlen    <= AWLEN;
            r_wsize   <= w_awsize;
            r_wburst  <= AWBURST;
            r_wbeat   <= LEN_SIZE'(0);
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wr_en) begin
            r_waddr <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
            r_wbeat <= r_wbeat + LEN_SIZE'(1);
`ifdef EI_AXI_SLV_WLAST_CHK_EN
            if (WLAST != w_wr_last) r_wlast_err <= 1'b1;
`endif
            if (w_wr_last) begin
              r_wready  <= 1'b0;
              r_awready <= 1'b1;
              r_wstate  <= W_IDLE;
            end
          end
        end
        default: begin
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_wstate  <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: the first beat is loaded at the AR handshake, later beats on
  // each accepted beat; a same-cycle write to that word is not yet visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= ADD_SIZE'(0);
      r_rlen    <= LEN_SIZE'(0);
      r_rbeat   <= LEN_SIZE'(0);
      r_rsize   <= S_SIZE'(0);
      r_rburst  <= BURST_SIZE'(0);
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= DATA_SIZE'(0);
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ARVALID && r_arready) begin
            r_raddr   <= f_next_addr(ARADDR, ARLEN, w_arsize, ARBURST);
            r_rlen    <= ARLEN;
            r_rsize   <= w_arsize;
            r_rburst  <= ARBURST;
            r_rbeat   <= LEN_SIZE'(0);
            r_rdata   <= r_mem[f_idx(ARADDR)];
            r_rvalid  <= 1'b1;
            r_rlast   <= (ARLEN == LEN_SIZE'(0));
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rdata <= r_mem[f_idx(r_raddr)];
              r_raddr <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
              r_rbeat <= r_rbeat + LEN_SIZE'(1);
              r_rlast <= ((r_rbeat + LEN_SIZE'(1)) == r_rlen);
            end
          end
        end
        default: begin
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
          r_arready <= 1'b0;
          r_rstate  <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ei_axi_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ei_axi_slave_mem
//   Directed bench for ei_axi_slave_mem: INCR write/read, WRAP read, narrow
//   FIXED write, read backpressure, reset mid-burst and (with
//   EI_AXI_SLV_WLAST_CHK_EN) the WLAST check. Expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_ei_axi_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
`ifdef EI_AXI_SLV_WLAST_CHK_EN
  logic        WLAST_ERR;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic        rl [16];
  int          rn;
  logic        bp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  ei_axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
`ifdef EI_AXI_SLV_WLAST_CHK_EN
    , .WLAST_ERR(WLAST_ERR)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_hs(input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    logic hs;
    hs = 1'b0;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      hs = AWREADY;
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b0;
    chk("aw_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic ar_hs(input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    logic hs;
    hs = 1'b0;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      hs = ARREADY;
      @(posedge ACLK); #1;
    end
    ARVALID = 1'b0;
    chk("ar_handshake", {31'd0, hs}, 32'd1);
  endtask

  // Sends nbeats of wd[]; WLAST is raised on beat index wlast_idx.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int nbeats, input int wlast_idx);
    logic hs;
    aw_hs(addr, len, size, burst);
    for (int i = 0; i < nbeats; i++) begin
      hs = 1'b0;
      WDATA = wd[i]; WLAST = (i == wlast_idx); WVALID = 1'b1;
      for (int c = 0; c < 20 && !hs; c++) begin
        hs = WREADY;
        @(posedge ACLK); #1;
      end
      chk("w_handshake", {31'd0, hs}, 32'd1);
    end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  // Collects beats into rd[]/rl[]; with use_bp RREADY follows bp[] first.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit use_bp);
    logic        v, l, rr, hl, stalled;
    logic [31:0] d, hd;
    stalled = 1'b0; hd = 32'd0; hl = 1'b0;
    ar_hs(addr, len, size, burst);
    rn = 0;
    for (int c = 0; c < 60 && rn < 16; c++) begin
      rr = (use_bp && c < 7) ? bp[c] : 1'b1;
      RREADY = rr;
      v = RVALID; d = RDATA; l = RLAST;
      if (stalled) begin
        chk("stall_rdata", d, hd);
        chk("stall_rlast", {31'd0, l}, {31'd0, hl});
      end
      stalled = v && !rr; hd = d; hl = l;
      @(posedge ACLK); #1;
      if (v && rr) begin
        rd[rn] = d; rl[rn] = l; rn++;
        if (l) break;
      end
    end
    RREADY = 1'b0;
    chk("read_beats", rn, 32'(len) + 32'd1);
    chk("rvalid_drop", {31'd0, RVALID}, 32'd0);
  endtask

  task automatic exp_beats(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_data"}, rd[i], e[i]);
      chk({tag, "_rlast"}, {31'd0, rl[i]}, {31'd0, (i == 3)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
    WDATA = 32'd0; WLAST = 1'b0; WVALID = 1'b0;
    ARADDR = 32'd0; ARLEN = 4'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_awready", {31'd0, AWREADY}, 32'd0);
    chk("rst_wready",  {31'd0, WREADY},  32'd0);
    chk("rst_arready", {31'd0, ARREADY}, 32'd0);
    chk("rst_rvalid",  {31'd0, RVALID},  32'd0);
    chk("rst_rlast",   {31'd0, RLAST},   32'd0);
    chk("rst_rdata",   RDATA,            32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("post_rst_awready", {31'd0, AWREADY}, 32'd1);
    chk("post_rst_arready", {31'd0, ARREADY}, 32'd1);

    // INCR write then read
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    axi_write(32'h10, 4'd3, 3'd2, 2'b01, 4, 3);
    axi_read(32'h10, 4'd3, 3'd2, 2'b01, 1'b0);
    exp_beats("incr", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // WRAP read: words 0x20..0x2C = 1..4, start at 0x28
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    axi_write(32'h20, 4'd3, 3'd2, 2'b01, 4, 3);
    axi_read(32'h28, 4'd3, 3'd2, 2'b10, 1'b0);
    exp_beats("wrap", 32'd3, 32'd4, 32'd1, 32'd2);

    // Narrow FIXED write into byte lane 1 of word 0x40
    wd[0] = 32'hFFFF_FFFF;
    axi_write(32'h40, 4'd0, 3'd2, 2'b01, 1, 0);
    wd[0] = 32'h0000_5500; wd[1] = 32'h0000_6600;
    axi_write(32'h41, 4'd1, 3'd0, 2'b00, 2, 1);
    axi_read(32'h40, 4'd0, 3'd2, 2'b01, 1'b0);
    chk("narrow_data", rd[0], 32'hFFFF_66FF);
    chk("narrow_rlast", {31'd0, rl[0]}, 32'd1);

    // Read backpressure
    axi_read(32'h10, 4'd3, 3'd2, 2'b01, 1'b1);
    exp_beats("bp", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Reset mid-burst: old contents 0x11..0x44, new burst cut after 2 beats
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    axi_write(32'h80, 4'd3, 3'd2, 2'b01, 4, 3);
    ar_hs(32'h10, 4'd3, 3'd2, 2'b01);
    wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
    axi_write(32'h80, 4'd3, 3'd2, 2'b01, 2, 3);
    chk("mid_wready", {31'd0, WREADY}, 32'd1);
    chk("mid_rvalid", {31'd0, RVALID}, 32'd1);
    ARESET = 1'b1;
    #1;
    chk("arst_wready", {31'd0, WREADY}, 32'd0);
    chk("arst_rvalid", {31'd0, RVALID}, 32'd0);
    chk("arst_awready", {31'd0, AWREADY}, 32'd0);
    chk("arst_rdata", RDATA, 32'd0);
    #3;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("rel_awready", {31'd0, AWREADY}, 32'd1);
    chk("rel_arready", {31'd0, ARREADY}, 32'd1);
    axi_read(32'h80, 4'd3, 3'd2, 2'b01, 1'b0);
    exp_beats("rstmid", 32'hB0, 32'hB1, 32'h33, 32'h44);

`ifdef EI_AXI_SLV_WLAST_CHK_EN
    chk("wlerr_clean", {31'd0, WLAST_ERR}, 32'd0);
    wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
    axi_write(32'hC0, 4'd3, 3'd2, 2'b01, 4, 1);
    chk("wlerr_set", {31'd0, WLAST_ERR}, 32'd1);
    axi_read(32'hC0, 4'd3, 3'd2, 2'b01, 1'b0);
    exp_beats("wlerr", 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    chk("wlerr_sticky", {31'd0, WLAST_ERR}, 32'd1);
    ARESET = 1'b1;
    #1;
    chk("wlerr_rst", {31'd0, WLAST_ERR}, 32'd0);
    #3;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
